// File: rtl/dcache_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dcache_ctrl_if : request type and bus bundle for the L1 data cache       |
// | controller (CPU port, data-memory port, next-level line port).           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

package dcache_pkg;
  typedef struct packed {
    logic       wr_en;
    logic       from_ram;
    logic [7:0] index;
    logic [2:0] block_offset;
    logic [3:0] byte_en;
  } cache_req_t;
endpackage

interface dcache_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32,
  parameter int LINE_LEN   = 256
);
  import dcache_pkg::*;

  logic                  cpu_req_valid_i;
  logic                  cpu_req_ready_o;
  logic [ADDR_WIDTH-1:0] cpu_addr_i;
  logic                  cpu_we_i;
  logic [3:0]            cpu_be_i;
  logic [WORD_WIDTH-1:0] cpu_wdata_i;
  logic                  cpu_rsp_valid_o;
  logic [WORD_WIDTH-1:0] cpu_rdata_o;
  cache_req_t            dmem_req_o;
  logic [LINE_LEN-1:0]   dmem_wdata_o;
  logic [LINE_LEN-1:0]   dmem_rdata_i;
  logic                  mem_req_valid_o;
  logic                  mem_req_ready_i;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [LINE_LEN-1:0]   mem_wdata_o;
  logic                  mem_rsp_valid_i;
  logic [LINE_LEN-1:0]   mem_rdata_i;

  modport slave (
    input  cpu_req_valid_i, cpu_addr_i, cpu_we_i, cpu_be_i, cpu_wdata_i,
    input  dmem_rdata_i, mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i,
    output cpu_req_ready_o, cpu_rsp_valid_o, cpu_rdata_o, dmem_req_o, dmem_wdata_o,
    output mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output cpu_req_valid_i, cpu_addr_i, cpu_we_i, cpu_be_i, cpu_wdata_i,
    output dmem_rdata_i, mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i,
    input  cpu_req_ready_o, cpu_rsp_valid_o, cpu_rdata_o, dmem_req_o, dmem_wdata_o,
    input  mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dcache_ctrl : direct-mapped write-back, write-allocate L1 D-cache        |
// | controller owning tag/valid/dirty state and the miss sequence.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int WORD_WIDTH     = 32,
  parameter int WORDS_PER_LINE = 8,
  parameter int NUM_LINES      = 256
) (
  input  wire logic   clk_i,
  input  wire logic   rst_ni,
  dcache_ctrl_if.slave bus
);
  localparam int LINE_LEN = WORDS_PER_LINE * WORD_WIDTH;
  localparam int BYTE_W   = $clog2(WORD_WIDTH / 8);
  localparam int OFF_W    = $clog2(WORDS_PER_LINE);
  localparam int IDX_W    = $clog2(NUM_LINES);
  localparam int LOW_W    = OFF_W + BYTE_W;
  localparam int TAG_W    = ADDR_WIDTH - IDX_W - LOW_W;

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LOOKUP      = 3'd1,
    S_WRITEBACK   = 3'd2,
    S_REFILL_REQ  = 3'd3,
    S_REFILL_WAIT = 3'd4,
    S_REREAD      = 3'd5
  } state_t;

  state_t                r_state, w_next;
  logic [TAG_W-1:0]      r_tag_arr [NUM_LINES];
  logic [NUM_LINES-1:0]  r_valid, r_dirty;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [3:0]            r_be;
  logic [WORD_WIDTH-1:0] r_wdata;
  logic [LINE_LEN-1:0]   r_victim;

  logic [IDX_W-1:0]      w_idx;
  logic [OFF_W-1:0]      w_off;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_hit, w_victim_dirty;
  logic                  w_set_dirty, w_capture, w_refill;
  logic                  w_ready, w_rsp_valid, w_mem_valid, w_mem_we;
  logic [WORD_WIDTH-1:0] w_rdata;
  cache_req_t            w_dmem_req;
  logic [LINE_LEN-1:0]   w_dmem_wdata, w_mem_wdata;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic                  w_unused;

  assign w_idx          = r_addr[LOW_W +: IDX_W];
  assign w_off          = r_addr[BYTE_W +: OFF_W];
  assign w_tag          = r_addr[ADDR_WIDTH-1 -: TAG_W];
  assign w_hit          = r_valid[w_idx] && (r_tag_arr[w_idx] == w_tag);
  assign w_victim_dirty = r_valid[w_idx] && r_dirty[w_idx];
  assign w_unused       = ^{bus.cpu_addr_i[BYTE_W-1:0], r_addr[BYTE_W-1:0]};

  always_comb begin
    w_next       = r_state;
    w_ready      = 1'b0;
    w_rsp_valid  = 1'b0;
    w_rdata      = '0;
    w_dmem_req   = '0;
    w_dmem_req.index = w_idx;
    w_dmem_wdata = '0;
    w_mem_valid  = 1'b0;
    w_mem_we     = 1'b0;
    w_mem_addr   = '0;
    w_mem_wdata  = '0;
    w_set_dirty  = 1'b0;
    w_capture    = 1'b0;
    w_refill     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready          = rst_ni;
        w_dmem_req.index = bus.cpu_addr_i[LOW_W +: IDX_W];
        if (bus.cpu_req_valid_i) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (w_hit) begin
          w_rsp_valid = 1'b1;
          w_next      = S_IDLE;
          if (r_we) begin
            w_dmem_req.wr_en        = 1'b1;
            w_dmem_req.byte_en      = r_be;
            w_dmem_req.block_offset = w_off;
            w_dmem_wdata[WORD_WIDTH-1:0] = r_wdata;
            w_set_dirty             = 1'b1;
          end else begin
            w_rdata = bus.dmem_rdata_i[w_off*WORD_WIDTH +: WORD_WIDTH];
          end
        end else if (w_victim_dirty) begin
          w_capture = 1'b1;
          w_next    = S_WRITEBACK;
        end else begin
          w_next = S_REFILL_REQ;
        end
      end
      S_WRITEBACK: begin
        // Victim tag is still in the array: it is only replaced on refill.
        w_mem_valid = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = {r_tag_arr[w_idx], w_idx, {LOW_W{1'b0}}};
        w_mem_wdata = r_victim;
        if (bus.mem_req_ready_i) w_next = S_REFILL_REQ;
      end
      S_REFILL_REQ: begin
        w_mem_valid = 1'b1;
        w_mem_addr  = {w_tag, w_idx, {LOW_W{1'b0}}};
        if (bus.mem_req_ready_i) w_next = S_REFILL_WAIT;
      end
      S_REFILL_WAIT: begin
        if (bus.mem_rsp_valid_i) begin
          w_dmem_req.wr_en    = 1'b1;
          w_dmem_req.from_ram = 1'b1;
          w_dmem_req.byte_en  = '1;
          w_dmem_wdata        = bus.mem_rdata_i;
          w_refill            = 1'b1;
          w_next              = S_REREAD;
        end
      end
      S_REREAD: w_next = S_LOOKUP;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_valid  <= '0;
      r_dirty  <= '0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_victim <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.cpu_req_valid_i) begin
        r_addr  <= bus.cpu_addr_i;
        r_we    <= bus.cpu_we_i;
        r_be    <= bus.cpu_be_i;
        r_wdata <= bus.cpu_wdata_i;
      end
      if (w_capture)   r_victim       <= bus.dmem_rdata_i;
      if (w_set_dirty) r_dirty[w_idx] <= 1'b1;
      if (w_refill) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_refill) r_tag_arr[w_idx] <= w_tag;
  end

  assign bus.cpu_req_ready_o = w_ready;
  assign bus.cpu_rsp_valid_o = w_rsp_valid;
  assign bus.cpu_rdata_o     = w_rdata;
  assign bus.dmem_req_o      = w_dmem_req;
  assign bus.dmem_wdata_o    = w_dmem_wdata;
  assign bus.mem_req_valid_o = w_mem_valid;
  assign bus.mem_we_o        = w_mem_we;
  assign bus.mem_addr_o      = w_mem_addr;
  assign bus.mem_wdata_o     = w_mem_wdata;

  a_rsp_only_in_wait: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.mem_rsp_valid_i |-> (r_state == S_REFILL_WAIT));
  a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.mem_req_valid_o && !bus.mem_req_ready_i) |=> bus.mem_req_valid_o);
endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dcache_ctrl : directed + random bench for dcache_ctrl against an      |
// | architectural memory model and a tag/valid/dirty cache model.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module tb_dcache_ctrl;
  import dcache_pkg::*;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  dcache_ctrl_if bus ();
  dcache_ctrl dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Environment: data memory array, next-level backing store, architectural words
  logic [255:0] dmem_arr [256];
  logic [255:0] backing  [int unsigned];
  logic [31:0]  ref_word [int unsigned];
  int           dm_wr_cnt = 0;
  logic [3:0]   dm_last_be;
  logic [2:0]   dm_last_off;
  logic         dm_last_from_ram;

  int           ready_delay = 0, rsp_delay = 1;
  bit           block_rsp = 0, inject_rsp = 0;
  int           wb_cnt = 0, rd_cnt = 0;
  logic [31:0]  last_wb_addr, last_rd_addr;
  logic [255:0] last_wb_data;

  bit           m_valid [256];
  bit           m_dirty [256];
  logic [18:0]  m_tag   [256];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] merge_store(input logic [255:0] line, input cache_req_t r,
                                               input logic [255:0] wd);
    for (int b = 0; b < 4; b++)
      if (r.byte_en[b]) line[r.block_offset*32 + b*8 +: 8] = wd[b*8 +: 8];
    return line;
  endfunction

  task automatic create_line(input logic [31:0] la);
    logic [255:0] l;
    logic [31:0]  wd;
    for (int w = 0; w < 8; w++) begin
      wd = $urandom;
      l[w*32 +: 32] = wd;
      ref_word[(la >> 2) + w] = wd;
    end
    backing[la] = l;
  endtask

  function automatic logic [255:0] ref_line(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = ref_word[(la >> 2) + w];
    return l;
  endfunction

  always @(posedge clk_i) begin
    if (bus.dmem_req_o.wr_en) begin
      dmem_arr[bus.dmem_req_o.index] <= bus.dmem_req_o.from_ram ? bus.dmem_wdata_o :
          merge_store(dmem_arr[bus.dmem_req_o.index], bus.dmem_req_o, bus.dmem_wdata_o);
      dm_wr_cnt        <= dm_wr_cnt + 1;
      dm_last_be       <= bus.dmem_req_o.byte_en;
      dm_last_off      <= bus.dmem_req_o.block_offset;
      dm_last_from_ram <= bus.dmem_req_o.from_ram;
    end
    bus.dmem_rdata_i <= dmem_arr[bus.dmem_req_o.index];
  end

  // Next-level memory: programmable ready stall, then one response per read
  initial begin : responder
    logic [31:0]  s_addr, p_addr;
    logic [255:0] s_data;
    logic         s_we;
    bit           in_req, pending;
    int           stall, pcnt;
    in_req = 0; pending = 0; stall = 0; pcnt = 0;
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rdata_i     = '0;
    forever begin
      @(posedge clk_i); #1;
      bus.mem_req_ready_i = 1'b0;
      bus.mem_rsp_valid_i = 1'b0;
      if (!rst_ni) begin
        bus.mem_rsp_valid_i = inject_rsp;
        bus.mem_rdata_i     = {8{32'hBAD0BAD0}};
        in_req = 0; pending = 0;
      end else begin
        if (pending) begin
          if (pcnt > 0) pcnt--;
          else if (!block_rsp) begin
            bus.mem_rsp_valid_i = 1'b1;
            bus.mem_rdata_i     = backing[p_addr];
            pending = 0;
          end
        end
        if (bus.mem_req_valid_o) begin
          if (!in_req) begin
            in_req = 1; stall = 0;
            s_addr = bus.mem_addr_o; s_data = bus.mem_wdata_o; s_we = bus.mem_we_o;
          end else begin
            chk("hold_addr", bus.mem_addr_o, s_addr);
            chk("hold_wdata", bus.mem_wdata_o, s_data);
            chk("hold_we", bus.mem_we_o, s_we);
          end
          if (stall < ready_delay) stall++;
          else begin
            bus.mem_req_ready_i = 1'b1;
            in_req = 0;
            if (s_we) begin
              wb_cnt++; last_wb_addr = s_addr; last_wb_data = s_data;
              backing[s_addr] = s_data;
            end else begin
              rd_cnt++; last_rd_addr = s_addr;
              if (!backing.exists(s_addr)) create_line(s_addr);
              pending = 1; p_addr = s_addr; pcnt = rsp_delay;
            end
          end
        end else if (in_req) begin
          chk("req_valid_held", bus.mem_req_valid_o, 1'b1);
          in_req = 0;
        end
      end
    end
  end

  task automatic start_req(input logic [31:0] a, input bit we, input logic [3:0] be,
                           input logic [31:0] wd);
    int n = 0;
    @(negedge clk_i);
    bus.cpu_req_valid_i = 1'b1; bus.cpu_addr_i = a; bus.cpu_we_i = we;
    bus.cpu_be_i = be; bus.cpu_wdata_i = wd;
    while (!bus.cpu_req_ready_o && n < 50) begin @(negedge clk_i); n++; end
    chk("req_ready", bus.cpu_req_ready_o, 1'b1);
    @(negedge clk_i);
    bus.cpu_req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(output logic [31:0] rd, output int lat);
    lat = 1;
    while (!bus.cpu_rsp_valid_o && lat < 300) begin @(negedge clk_i); lat++; end
    chk("rsp_seen", bus.cpu_rsp_valid_o, 1'b1);
    rd = bus.cpu_rdata_o;
    @(negedge clk_i);
    chk("rsp_single_cycle", bus.cpu_rsp_valid_o, 1'b0);
  endtask

  // One CPU access checked against the cache model and architectural memory
  task automatic op(input logic [31:0] a, input bit we, input logic [3:0] be,
                    input logic [31:0] wd, output logic [31:0] rd, output int lat);
    int unsigned idx = (a >> 5) & 32'hFF;
    logic [18:0] tag = a[31:13];
    logic [31:0] la  = {a[31:5], 5'b0};
    logic [31:0] va  = {m_tag[idx], idx[7:0], 5'b0};
    bit hit = m_valid[idx] && (m_tag[idx] == tag);
    bit wbx = !hit && m_valid[idx] && m_dirty[idx];
    int wb0 = wb_cnt, rd0 = rd_cnt;
    logic [31:0] w;
    start_req(a, we, be, wd);
    wait_rsp(rd, lat);
    chk("wb_count", wb_cnt - wb0, int'(wbx));
    chk("rd_count", rd_cnt - rd0, int'(!hit));
    if (wbx) begin
      chk("wb_addr", last_wb_addr, va);
      chk("wb_line", last_wb_data, ref_line(va));
    end
    if (!hit) chk("rd_addr", last_rd_addr, la);
    else      chk("hit_latency", lat, 1);
    if (!we) chk("load_data", rd, ref_word[a >> 2]);
    else begin
      w = ref_word[a >> 2];
      for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
      ref_word[a >> 2] = w;
    end
    m_valid[idx] = 1'b1;
    m_tag[idx]   = tag;
    if (!hit) m_dirty[idx] = 1'b0;
    if (we)   m_dirty[idx] = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, bus.cpu_req_ready_o, 1'b0);
    chk({tag, "_rsp"},   bus.cpu_rsp_valid_o, 1'b0);
    chk({tag, "_memv"},  bus.mem_req_valid_o, 1'b0);
    chk({tag, "_wren"},  bus.dmem_req_o.wr_en, 1'b0);
    chk({tag, "_rdata"}, bus.cpu_rdata_o, 32'h0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stim
    logic [31:0] rd;
    int          lat, r0, n, dw0;
    logic [31:0] a;
    bus.cpu_req_valid_i = 1'b0; bus.cpu_addr_i = '0; bus.cpu_we_i = 1'b0;
    bus.cpu_be_i = '0; bus.cpu_wdata_i = '0;
    for (int i = 0; i < 256; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = '0; end
    create_line(32'h100);
    ref_word[32'h104 >> 2] = 32'hDEADBEEF;
    backing[32'h100][63:32] = 32'hDEADBEEF;

    repeat (3) @(negedge clk_i);
    #1;
    chk_reset_outputs("reset");
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("ready_after_reset", bus.cpu_req_ready_o, 1'b1);

    // Cold load, then hit on the same word
    op(32'h104, 0, 4'h0, 0, rd, lat);
    chk("tp_cold_load", rd, 32'hDEADBEEF);
    chk("tp_cold_rd_addr", last_rd_addr, 32'h100);
    r0 = rd_cnt;
    op(32'h104, 0, 4'h0, 0, rd, lat);
    chk("tp_hit_latency", lat, 1);
    chk("tp_hit_no_mem", rd_cnt - r0, 0);

    // Partial store hit then read back
    dw0 = dm_wr_cnt;
    op(32'h104, 1, 4'b0011, 32'h0000_1234, rd, lat);
    chk("tp_store_wr_cnt", dm_wr_cnt - dw0, 1);
    chk("tp_store_be", dm_last_be, 4'b0011);
    chk("tp_store_off", dm_last_off, 3'd1);
    chk("tp_store_from_ram", dm_last_from_ram, 1'b0);
    op(32'h104, 0, 4'h0, 0, rd, lat);
    chk("tp_store_readback", rd, 32'hDEAD1234);

    // Eviction of the dirty line with a 5-cycle ready stall
    ready_delay = 5;
    op(32'h2104, 0, 4'h0, 0, rd, lat);
    ready_delay = 0;
    chk("tp_evict_wb_addr", last_wb_addr, 32'h100);
    chk("tp_evict_wb_word1", last_wb_data[63:32], 32'hDEAD1234);
    chk("tp_evict_rd_addr", last_rd_addr, 32'h2100);

    // Reset while waiting for a refill; a response during reset is ignored
    block_rsp = 1;
    r0 = rd_cnt;
    start_req(32'h4104, 0, 4'h0, 0);
    n = 0;
    while (rd_cnt == r0 && n < 100) begin @(negedge clk_i); n++; end
    chk("mid_miss_read_issued", rd_cnt - r0, 1);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b0; inject_rsp = 1;
    #1;
    chk_reset_outputs("mid_reset");
    @(negedge clk_i);
    inject_rsp = 0;
    chk_reset_outputs("mid_reset_rsp");
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1; block_rsp = 0;
    for (int i = 0; i < 256; i++) begin m_valid[i] = 0; m_dirty[i] = 0; end
    r0 = rd_cnt;
    op(32'h2104, 0, 4'h0, 0, rd, lat);
    chk("tp_after_reset_miss", rd_cnt - r0, 1);

    // Store with no byte enables still dirties the line
    op(32'h2108, 1, 4'b0000, 32'hFFFF_FFFF, rd, lat);
    op(32'h0104, 0, 4'h0, 0, rd, lat);
    chk("be0_dirty_wb_addr", last_wb_addr, 32'h2100);

    // Random traffic over a few indexes and tags
    for (int k = 0; k < 120; k++) begin
      int unsigned sel = $urandom_range(0, 2);
      int unsigned idx = (sel == 0) ? 3 : (sel == 1) ? 8 : 9;
      a = ($urandom_range(0, 3) << 13) | (idx << 5) | ($urandom_range(0, 7) << 2);
      ready_delay = $urandom_range(0, 2);
      rsp_delay   = $urandom_range(0, 3);
      op(a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, rd, lat);
    end

    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
